// File: rtl/adler32_feeder.sv
// adler32_feeder
//
// Front-end stage for the Adler-32 offload engine. It takes a job command
// (message length in bytes) and a stream of 32-bit words, buffers the words
// in a small FIFO, and replays them to the engine as a gap-free byte stream:
// one size beat, one data_start beat, then one byte per clock. The engine's
// checksum pulse is captured into a held result with its own valid/ready
// handshake. Zero-length commands, FIFO underrun while streaming and a
// missing engine checksum are reported as one-cycle error pulses.
//
// Configuration macro:
//   ADLER32_FEED_BIG_ENDIAN_EN  defined   -> first byte of a word is [31:24]
//                               undefined -> first byte of a word is [7:0]
//
// Parameters:
//   FIFO_DEPTH  word FIFO entries (power of two, >= 2)
//   WAIT_MAX    cycles allowed from the last byte to the engine checksum
//
// Ports:
//   clock, rst                 clock and synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_len                job command handshake
//   in_valid/in_ready/in_data                  32-bit word stream
//   eng_size_valid/eng_size                    size beat to the engine
//   eng_data_start/eng_data                    start beat and byte stream
//   eng_checksum_valid/eng_checksum            checksum from the engine
//   res_valid/res_ready/res_checksum           held result handshake
//   err/err_code                               error pulse, 1=zero length,
//                                              2=underrun, 3=timeout
module adler32_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int WAIT_MAX   = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        eng_size_valid,
    output logic [31:0] eng_size,
    output logic        eng_data_start,
    output logic [7:0]  eng_data,
    input  logic        eng_checksum_valid,
    input  logic [31:0] eng_checksum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_checksum,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIZE,
        ST_FILL,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [31:0]   len_q;
    logic [31:0]   words_total_q;
    logic [31:0]   words_acc_q;
    logic [31:0]   bytes_sent_q;
    logic [1:0]    byte_idx_q;
    logic [31:0]   wait_cnt_q;
    logic [31:0]   res_checksum_q;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          last_byte;
    logic          flush;
    logic          err_c;
    logic [1:0]    err_code_c;
    logic [31:0]   head;
    logic [7:0]    head_byte;

    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign last_byte  = (bytes_sent_q == len_q - 32'd1);

    // A word leaves the FIFO after its 4th byte or after the message's final
    // byte; because the freed slot is usable in the same cycle, a full FIFO
    // can still accept a word while it pops.
    assign pop  = (state == ST_STREAM) && !fifo_empty && ((byte_idx_q == 2'd3) || last_byte);
    assign push = in_valid && in_ready;

    assign in_ready = ((state == ST_FILL) || (state == ST_START) || (state == ST_STREAM))
                      && ((count_q != DEPTH_C) || pop)
                      && (words_acc_q < words_total_q);

`ifdef ADLER32_FEED_BIG_ENDIAN_EN
    assign head_byte = head[{~byte_idx_q, 3'b000} +: 8];
`else
    assign head_byte = head[{byte_idx_q, 3'b000} +: 8];
`endif

    // cmd_ready is masked while reset is held so it only rises once the
    // feeder is actually free to run.
    assign cmd_ready      = (state == ST_IDLE) && !rst;
    assign eng_size_valid = (state == ST_SIZE);
    assign eng_size       = (state == ST_SIZE) ? len_q : 32'd0;
    assign eng_data_start = (state == ST_START);
    assign eng_data       = ((state == ST_STREAM) && !fifo_empty) ? head_byte : 8'd0;
    assign res_valid      = (state == ST_DONE);
    assign res_checksum   = res_checksum_q;
    assign err            = err_c && !rst;
    assign err_code       = rst ? 2'd0 : err_code_c;

    // Next-state and error decode. FILL looks at the counts including this
    // cycle's push so a short message can start right after one FILL cycle.
    always_comb begin
        state_next = state;
        err_c      = 1'b0;
        err_code_c = 2'd0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == 32'd0) begin
                        err_c      = 1'b1;
                        err_code_c = 2'd1;
                    end else begin
                        state_next = ST_SIZE;
                    end
                end
            end
            ST_SIZE: state_next = ST_FILL;
            ST_FILL: begin
                if ((count_q + (AW + 1)'(push) == DEPTH_C) ||
                    (words_acc_q + 32'(push) == words_total_q)) begin
                    state_next = ST_START;
                end
            end
            ST_START: state_next = ST_STREAM;
            ST_STREAM: begin
                if (fifo_empty) begin
                    err_c      = 1'b1;
                    err_code_c = 2'd2;
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (last_byte) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_checksum_valid) begin
                    state_next = ST_DONE;
                end else if (wait_cnt_q == 32'(WAIT_MAX - 1)) begin
                    err_c      = 1'b1;
                    err_code_c = 2'd3;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, job counters, FIFO pointers and the captured result.
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            words_total_q  <= '0;
            words_acc_q    <= '0;
            bytes_sent_q   <= '0;
            byte_idx_q     <= '0;
            wait_cnt_q     <= '0;
            res_checksum_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE) begin
                words_acc_q  <= '0;
                bytes_sent_q <= '0;
                byte_idx_q   <= '0;
                wait_cnt_q   <= '0;
                if (cmd_valid) begin
                    len_q         <= cmd_len;
                    words_total_q <= {2'b00, cmd_len[31:2]} + 32'(cmd_len[1:0] != 2'b00);
                end
            end

            if (push) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                words_acc_q <= words_acc_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);

            if ((state == ST_STREAM) && !fifo_empty) begin
                bytes_sent_q <= bytes_sent_q + 32'd1;
                byte_idx_q   <= last_byte ? 2'd0 : byte_idx_q + 2'd1;
            end

            if (state == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
                if (eng_checksum_valid) begin
                    res_checksum_q <= eng_checksum;
                end
            end

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end
        end
    end

    // FIFO storage needs no reset; only words below count_q are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: doc/adler32_feeder.md
# adler32_feeder

Front-end stage for the Adler-32 offload engine. It accepts a job command (byte length) and a 32-bit word stream over valid/ready handshakes, and buffers the words in a small FIFO. It converts them into the engine's gap-free byte protocol (size_valid/size, data_start, one byte per clock). It captures the engine's checksum pulse into a held result with its own valid/ready handshake, and flags length, underrun and timeout errors.

## Interface
- FIFO_DEPTH, 8: word FIFO entries; power of two, ≥2.
- WAIT_MAX, 16: cycles allowed from last byte to engine checksum_valid.
- clock  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job command valid.
- cmd_ready  out  1  feeder idle, can take a command.
- cmd_len  in  32  message length in bytes.
- in_valid  in  1  data word valid.
- in_ready  out  1  feeder accepts word this cycle.
- in_data  in  32  four message bytes.
- eng_size_valid  out  1  to engine size_valid.
- eng_size  out  32  to engine size.
- eng_data_start  out  1  to engine data_start.
- eng_data  out  8  to engine data.
- eng_checksum_valid  in  1  from engine.
- eng_checksum  in  32  from engine, {B,A}.
- res_valid  out  1  result held.
- res_ready  in  1  result consumed.
- res_checksum  out  32  captured checksum.
- err  out  1  one-cycle error pulse.
- err_code  out  2  1=zero length, 2=underrun, 3=timeout; valid with err.

## Operation
- States: IDLE, SIZE, FILL, START, STREAM, WAIT, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch len, compute words_total=ceil(len/4). If len==0, pulse err/code 1 and stay IDLE; else go to SIZE.
- SIZE: eng_size_valid=1, eng_size=len for exactly one cycle, then FILL.
- in_ready=1 when state ∈ {FILL, START, STREAM}, FIFO not full, and words_accepted<words_total. Words beyond words_total are never accepted.
- FILL: go to START when FIFO count==FIFO_DEPTH or words_accepted==words_total.
- START: eng_data_start=1 for one cycle; eng_data=0. Then STREAM.
- STREAM: emit one byte per cycle from the FIFO head word. Byte order is per Configuration.
  - Pop the word after its 4th byte, or after the final byte of the message.
  - Bytes of the final word past len are discarded.
  - After len bytes, go to WAIT.
- Underrun: FIFO empty in STREAM with bytes remaining. Pulse err/code 2, flush FIFO, go to IDLE. No checksum is captured.
- WAIT: on eng_checksum_valid, capture eng_checksum into res_checksum and go to DONE. If WAIT_MAX cycles elapse without it, pulse err/code 3 and go to IDLE.
- DONE: res_valid=1 and res_checksum stable until res_ready, then IDLE.
- eng_checksum_valid outside WAIT is ignored.
- Byte counter and word counter are 32-bit; no wrap for lengths ≤ 2^32−1.

## Timing
- Reset values: cmd_ready=0 during reset and 1 the cycle after. All other outputs 0, FIFO empty, state IDLE.
- Reset mid-job: abort immediately; no err pulse.
- Command accept to eng_size_valid: 1 cycle.
- eng_size_valid to earliest eng_data_start: 2 cycles (one FILL cycle minimum).
- First byte appears on eng_data the cycle after eng_data_start; subsequent bytes on consecutive cycles, no gaps.
- eng_data=0 whenever not in STREAM.
- FIFO push and pop in the same cycle are allowed; a pop frees the slot in that same cycle.
- res_valid drops the cycle after res_valid&&res_ready. cmd_ready rises in that same cycle.

## Configuration
- ADLER32_FEED_BIG_ENDIAN_EN defined: the first byte of each word is in_data[31:24], then [23:16], [15:8], [7:0].
- Undefined (default): the first byte is in_data[7:0], ascending.
- Partial final word: the valid bytes are the first len%4 in the selected order.

## Test plan
- "Wikipedia" test:
  - Stimulus: len=9; words 0x696B6957, 0x69646570, 0xDEADBE61 (little-endian); engine model attached.
  - Response: eng_data sequence 57 69 6B 69 70 65 64 69 61, no gaps; res_checksum=0x11E60398.
- Zero length: cmd_len=0 -> err=1, err_code=1 for one cycle; no eng_size_valid; cmd_ready stays 1.
- Underrun:
  - Stimulus: len=64, FIFO_DEPTH=8; supply 8 words, then hold in_valid=0.
  - Response: after 32 bytes, err with code 2, return to IDLE, res_valid never asserts.
- Timeout: len=4, engine never pulses checksum_valid -> err code 3 exactly WAIT_MAX cycles after the last byte.
- Backpressure: hold res_ready=0 for 20 cycles -> res_valid and res_checksum stay stable, cmd_ready=0; release -> next command accepted.
- Reset mid-STREAM: assert rst at byte 5 of 16 -> next cycle all outputs 0; a fresh len=1 job (byte 0x01) gives res_checksum=0x00020002.
